mole_round_ctrl: RTL and testbench
==================================

Name: mole_round_ctrl

Overview:
- Game-round controller sitting directly downstream of the random mole selector in the whack-a-mole design.
- Drives the selector's trigger input to open a fixed-length "mole visible" window, then reads back the 18-bit one-hot mole pattern.
- Compares player switch rising edges against that pattern.
- Emits hit/miss pulses, keeps a saturating score, counts rounds and flags game over.

Parameters:
- SHOW_CYCLES, 50_000_000: clock cycles the mole stays visible per round (trigger high), min 3.
- GAP_CYCLES, 25_000_000: clock cycles between rounds (trigger low), min 1.
- ROUNDS, 20: rounds per game, 1..255.
- SCORE_W, 8: score width; score saturates at 2^SCORE_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  level; game begins on the first cycle sampled high while in IDLE
- sw  in  18  raw player switches, asynchronous to clk
- mole  in  18  one-hot mole pattern from the selector's displayL; all-zero when trigger is low
- trigger  out  1  to the selector; high for the whole SHOW state
- hit_pulse  out  1  one-cycle pulse on a correct whack
- miss_pulse  out  1  one-cycle pulse on a wrong switch or timeout
- score  out  SCORE_W  hits this game
- round_idx  out  8  number of rounds completed this game
- busy  out  1  high in GAP, SHOW and RESOLVE
- game_over  out  1  high in DONE

Behaviour:
- Clocking: one clock domain (clk). Reset is synchronous, active-high.
- Reset values: trigger=0, hit_pulse=0, miss_pulse=0, score=0, round_idx=0, busy=0, game_over=0. FSM goes to IDLE, counters clear, both switch synchroniser stages and sw_prev clear.
- Switch input path: sw passes through a 2-flop synchroniser giving sw_s. sw_prev is a register of sw_s.
  - Rising-edge vector: rise = sw_s & ~sw_prev.
  - In IDLE, GAP and DONE, sw_prev is loaded from sw_s every cycle, so switches held across states never register as edges.
- FSM states: IDLE, GAP, SHOW, RESOLVE, DONE.
- IDLE:
  - start=1 clears score and round_idx, loads the timer with GAP_CYCLES-1, goes to GAP.
  - All other inputs are ignored.
- GAP:
  - trigger=0; the timer decrements.
  - When timer=0: load SHOW_CYCLES-1, go to SHOW.
- SHOW:
  - trigger=1; the timer decrements.
  - The selector latches mole on the trigger rising edge, so mole is valid from the 2nd SHOW cycle on. In the 1st SHOW cycle, rise is ignored and sw_prev updates.
  - Decision, from the 2nd SHOW cycle on, evaluated in this priority order:
    - (a) (rise & mole) != 0 → hit.
    - (b) else rise != 0 → miss (wrong switch).
    - (c) else timer=0 → miss (timeout).
  - If a hit edge and timeout occur in the same cycle, hit wins. Multiple simultaneous rising bits count as a hit if any bit matches mole.
  - On a decision: go to RESOLVE, and trigger drops the next cycle.
- RESOLVE (exactly 1 cycle):
  - trigger=0; exactly one of hit_pulse/miss_pulse is high.
  - On a hit, score increments, saturating at all-ones.
  - round_idx increments.
  - If the incremented round_idx equals ROUNDS, go to DONE; otherwise load GAP_CYCLES-1 and go to GAP.
- DONE:
  - game_over=1; score and round_idx hold.
  - start=1 clears game_over and goes to IDLE next cycle; a new game then needs start sampled in IDLE.
- start is ignored in GAP, SHOW and RESOLVE.
- Latencies:
  - trigger rises exactly GAP_CYCLES cycles after entering GAP.
  - A timeout round holds trigger high for exactly SHOW_CYCLES cycles.
  - hit_pulse appears 3 cycles after a qualifying sw edge at the pin: 2 synchroniser cycles plus 1 cycle into RESOLVE.
- Reset mid-game: returns to IDLE immediately, trigger deasserts the next cycle, no pulse is emitted.
- The timer is wide enough for max(SHOW_CYCLES, GAP_CYCLES); its width is derived with $clog2.

Decomposition:
- Shared package mole_pkg holds:
  - the state enum;
  - the constant NUM_HOLES=18, used for the mole, sw and selector widths;
  - the score saturation helper function.
- One natural sub-module, sw_edge_sync: the 18-bit 2-flop synchroniser plus the rising-edge detector with a "rearm" input that loads sw_prev.

Test Plan (SHOW_CYCLES=8, GAP_CYCLES=4, ROUNDS=3):
- Reset held 3 cycles, then released with start=0 → all outputs 0, trigger stays 0 for 20 cycles.
- start pulse; the bench model latches mole=18'h00020 on trigger rise; sw[5] rises on the 4th SHOW cycle → hit_pulse 3 cycles later, score=1, round_idx=1, trigger low the cycle after the decision.
- Same setup but sw[6] rises → miss_pulse, score unchanged at 1, round_idx=2.
- No switch activity → trigger high exactly 8 cycles, then miss_pulse, round_idx=3, game_over=1, busy=0.
- sw[5] held high from IDLE through SHOW with mole=bit5 → no hit, timeout miss (no edge seen). Separately, sw[5] edge on the exact cycle timer=0 → hit wins.
- Reset asserted mid-SHOW → next cycle trigger=0, score=0, round_idx=0, no pulses. start in DONE → IDLE, then start → new game with score=0.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole round controller: hole count,
// round-controller state encoding and the score saturation helper.
package mole_pkg;

   localparam int NUM_HOLES = 18;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GAP     = 3'd1,
      ST_SHOW    = 3'd2,
      ST_RESOLVE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Increment value but stick at all-ones for a counter of the given width
   // (width must be 31 or less).
   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input int unsigned width);
      logic [31:0] max_val;
      max_val = (32'd1 << width) - 32'd1;
      if (value >= max_val)
         return max_val;
      return value + 32'd1;
   endfunction

endpackage

// File: rtl/sw_edge_sync.sv
// Two-flop synchroniser for the raw player switches followed by a
// rising-edge detector. "rearm" snaps the edge reference to the current
// switch levels so switches that are already held down never look like
// fresh presses.
module sw_edge_sync
   import mole_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_HOLES-1:0] sw,
   input  logic                 rearm,
   output logic [NUM_HOLES-1:0] rise
);

   logic [NUM_HOLES-1:0] sync1;
   logic [NUM_HOLES-1:0] sw_s;
   logic [NUM_HOLES-1:0] sw_prev;

   // Synchronise the switches and track the edge reference; while not
   // rearmed, released bits drop out of the reference so a re-press counts.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= '0;
         sw_s    <= '0;
         sw_prev <= '0;
      end else begin
         sync1 <= sw;
         sw_s  <= sync1;
         if (rearm)
            sw_prev <= sw_s;
         else
            sw_prev <= sw_prev & sw_s;
      end
   end

   assign rise = sw_s & ~sw_prev;

endmodule

// File: rtl/mole_round_ctrl.sv
// Round controller for the whack-a-mole game: times the gap and visible
// windows, triggers the mole selector, judges player presses against the
// shown mole, and keeps score and round count until the game ends.
module mole_round_ctrl
   import mole_pkg::*;
#(
   parameter int SHOW_CYCLES = 50_000_000,
   parameter int GAP_CYCLES  = 25_000_000,
   parameter int ROUNDS      = 20,
   parameter int SCORE_W     = 8
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [NUM_HOLES-1:0] sw,
   input  logic [NUM_HOLES-1:0] mole,
   output logic                 trigger,
   output logic                 hit_pulse,
   output logic                 miss_pulse,
   output logic [SCORE_W-1:0]   score,
   output logic [7:0]           round_idx,
   output logic                 busy,
   output logic                 game_over
);

   localparam int MAX_CYCLES = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
   localparam int TIMER_W    = $clog2(MAX_CYCLES);
   localparam logic [TIMER_W-1:0] SHOW_LOAD   = TIMER_W'(SHOW_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD    = TIMER_W'(GAP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
   localparam logic [7:0]         ROUNDS_LAST = 8'(ROUNDS);

   state_t               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [7:0]           round_q, round_d;
   logic                 hit_q, hit_d;
   logic                 rearm;
   logic                 first_show;
   logic [NUM_HOLES-1:0] rise;

   sw_edge_sync u_sw_edge_sync (
      .clk   (clk),
      .reset (reset),
      .sw    (sw),
      .rearm (rearm),
      .rise  (rise)
   );

   // The timer is loaded with SHOW_LOAD on entry to SHOW and then counts
   // down, so this only holds in the first SHOW cycle, before mole is valid.
   assign first_show = (timer_q == SHOW_LOAD);

   assign score     = score_q;
   assign round_idx = round_q;

   // State, timer, score, round count and the pending hit/miss verdict.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         score_q <= '0;
         round_q <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         score_q <= score_d;
         round_q <= round_d;
         hit_q   <= hit_d;
      end
   end

   // Round sequencing, press judging and the state-decoded outputs.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      score_d    = score_q;
      round_d    = round_q;
      hit_d      = hit_q;
      rearm      = 1'b0;
      trigger    = 1'b0;
      hit_pulse  = 1'b0;
      miss_pulse = 1'b0;
      busy       = 1'b0;
      game_over  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            rearm = 1'b1;
            if (start) begin
               score_d = '0;
               round_d = '0;
               timer_d = GAP_LOAD;
               state_d = ST_GAP;
            end
         end

         ST_GAP: begin
            rearm = 1'b1;
            busy  = 1'b1;
            if (timer_q == '0) begin
               timer_d = SHOW_LOAD;
               state_d = ST_SHOW;
            end else begin
               timer_d = timer_q - TIMER_ONE;
            end
         end

         ST_SHOW: begin
            trigger = 1'b1;
            busy    = 1'b1;
            if (first_show) begin
               rearm   = 1'b1;
               timer_d = timer_q - TIMER_ONE;
            end else if (((rise & mole) != '0) || (rise != '0) || (timer_q == '0)) begin
               hit_d   = ((rise & mole) != '0);
               round_d = round_q + 8'd1;
               if ((rise & mole) != '0)
                  score_d = SCORE_W'(sat_inc(32'(score_q), SCORE_W));
               state_d = ST_RESOLVE;
            end else begin
               timer_d = timer_q - TIMER_ONE;
            end
         end

         ST_RESOLVE: begin
            busy       = 1'b1;
            hit_pulse  = hit_q;
            miss_pulse = ~hit_q;
            if (round_q == ROUNDS_LAST) begin
               state_d = ST_DONE;
            end else begin
               timer_d = GAP_LOAD;
               state_d = ST_GAP;
            end
         end

         ST_DONE: begin
            rearm     = 1'b1;
            game_over = 1'b1;
            if (start)
               state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Randomised and directed bench for mole_round_ctrl, checked every cycle
// against a behavioural game model that counts cycles in each phase.
module tb_mole_round_ctrl;
   import mole_pkg::*;

   localparam int SHOW_CYCLES = 8;
   localparam int GAP_CYCLES  = 4;
   localparam int ROUNDS      = 3;
   localparam int SCORE_W     = 1;
   localparam int SCORE_MAX   = (1 << SCORE_W) - 1;

   localparam int M_IDLE    = 0;
   localparam int M_GAP     = 1;
   localparam int M_SHOW    = 2;
   localparam int M_RESOLVE = 3;
   localparam int M_DONE    = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 start;
   logic [NUM_HOLES-1:0] sw;
   logic [NUM_HOLES-1:0] mole;
   logic                 trigger;
   logic                 hit_pulse;
   logic                 miss_pulse;
   logic [SCORE_W-1:0]   score;
   logic [7:0]           round_idx;
   logic                 busy;
   logic                 game_over;

   int vectors     = 0;
   int miscompares = 0;

   int                   m_phase;
   int                   m_cnt;
   int                   m_score;
   int                   m_rounds;
   bit                   m_hit;
   logic [NUM_HOLES-1:0] m_s1, m_s2, m_s2d;
   logic [NUM_HOLES-1:0] mole_pat;
   logic [NUM_HOLES-1:0] swv;
   int                   trig_count;

   mole_round_ctrl #(
      .SHOW_CYCLES (SHOW_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES),
      .ROUNDS      (ROUNDS),
      .SCORE_W     (SCORE_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .sw         (sw),
      .mole       (mole),
      .trigger    (trigger),
      .hit_pulse  (hit_pulse),
      .miss_pulse (miss_pulse),
      .score      (score),
      .round_idx  (round_idx),
      .busy       (busy),
      .game_over  (game_over)
   );

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // The selector shows its latched mole from the second visible cycle on.
   function automatic logic [NUM_HOLES-1:0] selectorMole();
      if (m_phase == M_SHOW && m_cnt >= 1)
         return mole_pat;
      return '0;
   endfunction

   // Advance the game model by one clock with the inputs the DUT will sample.
   task automatic modelStep(input logic r, input logic st,
                            input logic [NUM_HOLES-1:0] swp,
                            input logic [NUM_HOLES-1:0] mv);
      logic [NUM_HOLES-1:0] pressed;
      bit decided;
      pressed = m_s2 & ~m_s2d;
      decided = 1'b0;
      if (r) begin
         m_phase  = M_IDLE;
         m_cnt    = 0;
         m_hit    = 1'b0;
         m_score  = 0;
         m_rounds = 0;
         m_s1     = '0;
         m_s2     = '0;
         m_s2d    = '0;
         return;
      end
      case (m_phase)
         M_IDLE: if (st) begin
            m_score  = 0;
            m_rounds = 0;
            m_cnt    = 0;
            m_phase  = M_GAP;
         end
         M_GAP: begin
            if (m_cnt == GAP_CYCLES - 1) begin
               m_phase = M_SHOW;
               m_cnt   = 0;
            end else begin
               m_cnt++;
            end
         end
         M_SHOW: begin
            if (m_cnt >= 1 && (pressed & mv) != '0) begin
               decided = 1'b1;
               m_hit   = 1'b1;
            end else if (m_cnt >= 1 && pressed != '0) begin
               decided = 1'b1;
               m_hit   = 1'b0;
            end else if (m_cnt == SHOW_CYCLES - 1) begin
               decided = 1'b1;
               m_hit   = 1'b0;
            end
            if (decided) begin
               m_phase = M_RESOLVE;
               m_rounds++;
               if (m_hit && m_score < SCORE_MAX)
                  m_score++;
            end else begin
               m_cnt++;
            end
         end
         M_RESOLVE: begin
            if (m_rounds == ROUNDS) begin
               m_phase = M_DONE;
            end else begin
               m_phase = M_GAP;
               m_cnt   = 0;
            end
         end
         default: if (st) m_phase = M_IDLE;
      endcase
      m_s2d = m_s2;
      m_s2  = m_s1;
      m_s1  = swp;
   endtask

   task automatic checkAll();
      checkOutput("trigger",    32'(trigger),    32'(m_phase == M_SHOW));
      checkOutput("hit_pulse",  32'(hit_pulse),  32'(m_phase == M_RESOLVE && m_hit));
      checkOutput("miss_pulse", 32'(miss_pulse), 32'(m_phase == M_RESOLVE && !m_hit));
      checkOutput("score",      32'(score),      32'(m_score));
      checkOutput("round_idx",  32'(round_idx),  32'(m_rounds));
      checkOutput("busy",       32'(busy),
                  32'(m_phase == M_GAP || m_phase == M_SHOW || m_phase == M_RESOLVE));
      checkOutput("game_over",  32'(game_over),  32'(m_phase == M_DONE));
   endtask

   // One cycle: check the current cycle, then drive the next inputs.
   task automatic applyStimulus(input logic r, input logic st,
                                input logic [NUM_HOLES-1:0] swp);
      logic [NUM_HOLES-1:0] mv;
      @(negedge clk);
      checkAll();
      mv    = selectorMole();
      reset = r;
      start = st;
      sw    = swp;
      mole  = mv;
      modelStep(r, st, swp, mv);
   endtask

   task automatic runUntil(input int phase, input int cnt, input int budget,
                           input logic [NUM_HOLES-1:0] swp, input string tag);
      int waited;
      waited = 0;
      while (!(m_phase == phase && m_cnt == cnt) && waited < budget) begin
         applyStimulus(1'b0, 1'b0, swp);
         waited++;
      end
      checkOutput(tag, 32'(m_phase == phase && m_cnt == cnt), 32'd1);
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      sw       = '0;
      mole     = '0;
      mole_pat = 18'h00020;
      modelStep(1'b1, 1'b0, '0, '0);

      // Reset held three cycles, then quiet idle.
      repeat (3) applyStimulus(1'b1, 1'b0, '0);
      repeat (20) applyStimulus(1'b0, 1'b0, '0);
      checkOutput("idle_trigger", 32'(trigger), 32'd0);

      // Round 1: correct whack on the 4th visible cycle.
      applyStimulus(1'b0, 1'b1, '0);
      runUntil(M_SHOW, 3, 40, '0, "reach_show1");
      repeat (4) applyStimulus(1'b0, 1'b0, 18'h00020);
      checkOutput("hit_lat3",    32'(hit_pulse), 32'd1);
      checkOutput("hit_score",   32'(score),     32'd1);
      checkOutput("hit_round",   32'(round_idx), 32'd1);
      checkOutput("hit_trig_lo", 32'(trigger),   32'd0);

      // Round 2: wrong switch.
      runUntil(M_SHOW, 3, 40, '0, "reach_show2");
      repeat (4) applyStimulus(1'b0, 1'b0, 18'h00040);
      checkOutput("wrong_miss",  32'(miss_pulse), 32'd1);
      checkOutput("wrong_score", 32'(score),      32'd1);
      checkOutput("wrong_round", 32'(round_idx),  32'd2);

      // Round 3: no activity, timeout ends the game.
      runUntil(M_SHOW, 0, 40, 18'h00040, "reach_show3");
      trig_count = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 1'b0, 18'h00040);
         if (trigger === 1'b1) trig_count++;
         if (m_phase == M_RESOLVE) break;
      end
      checkOutput("timeout_len", 32'(trig_count), 32'd8);
      applyStimulus(1'b0, 1'b0, 18'h00040);
      checkOutput("timeout_miss",  32'(miss_pulse), 32'd1);
      checkOutput("timeout_round", 32'(round_idx),  32'd3);
      applyStimulus(1'b0, 1'b0, 18'h00040);
      checkOutput("done_flag", 32'(game_over), 32'd1);
      checkOutput("done_busy", 32'(busy),      32'd0);

      // start in DONE returns to IDLE; new game with sw[5] held from IDLE.
      applyStimulus(1'b0, 1'b1, 18'h00040);
      applyStimulus(1'b0, 1'b0, 18'h00020);
      checkOutput("done_to_idle", 32'(game_over), 32'd0);
      repeat (3) applyStimulus(1'b0, 1'b0, 18'h00020);
      applyStimulus(1'b0, 1'b1, 18'h00020);
      applyStimulus(1'b0, 1'b0, 18'h00020);
      checkOutput("new_game_score", 32'(score), 32'd0);
      checkOutput("new_game_busy",  32'(busy),  32'd1);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b0, 1'b0, 18'h00020);
         if (m_phase == M_RESOLVE) break;
      end
      applyStimulus(1'b0, 1'b0, 18'h00020);
      checkOutput("held_no_hit", 32'(hit_pulse),  32'd0);
      checkOutput("held_miss",   32'(miss_pulse), 32'd1);

      // Press edge lands exactly on the timeout cycle: hit wins.
      runUntil(M_SHOW, SHOW_CYCLES - 3, 40, '0, "reach_show_edge");
      repeat (4) applyStimulus(1'b0, 1'b0, 18'h00020);
      checkOutput("edge_at_timeout_hit", 32'(hit_pulse), 32'd1);
      checkOutput("edge_at_timeout_scr", 32'(score),     32'd1);

      // Reset in the middle of a visible window.
      runUntil(M_SHOW, 4, 40, '0, "reach_show_rst");
      applyStimulus(1'b0, 1'b1, '0);
      applyStimulus(1'b1, 1'b0, '0);
      applyStimulus(1'b0, 1'b0, '0);
      checkOutput("rst_trigger", 32'(trigger),    32'd0);
      checkOutput("rst_score",   32'(score),      32'd0);
      checkOutput("rst_round",   32'(round_idx),  32'd0);
      checkOutput("rst_hit",     32'(hit_pulse),  32'd0);
      checkOutput("rst_miss",    32'(miss_pulse), 32'd0);

      // Random play.
      swv = '0;
      for (int i = 0; i < 3000; i++) begin
         logic r, st;
         r  = ($urandom_range(0, 599) == 0);
         st = ($urandom_range(0, 7) == 0);
         if (m_phase != M_SHOW)
            mole_pat = 18'd1 << $urandom_range(0, 17);
         if ($urandom_range(0, 5) == 0) begin
            if (m_phase == M_SHOW && $urandom_range(0, 1) == 1)
               swv = swv | mole_pat;
            else
               swv = swv ^ (18'd1 << $urandom_range(0, 17));
         end
         if ($urandom_range(0, 15) == 0)
            swv = '0;
         applyStimulus(r, st, swv);
      end
      applyStimulus(1'b0, 1'b0, swv);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
